// File: rtl/oq_dequeue_sched.sv
// Round-robin dequeue scheduler for the output-queue SRAM remove pipeline.
// Issues one read at a time, waits for completion, then settles before re-arbitrating.
module oq_dequeue_sched #(
   parameter int unsigned NUM_OUTPUT_QUEUES = 8,
   parameter int unsigned NUM_OQ_WIDTH      = $clog2(NUM_OUTPUT_QUEUES),
   parameter int unsigned SETTLE_CYCLES     = 2,
   parameter int unsigned TIMEOUT_WIDTH     = 12
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_OUTPUT_QUEUES-1:0] empty,
   input  logic [NUM_OUTPUT_QUEUES-1:0] out_rdy,
   input  logic [NUM_OUTPUT_QUEUES-1:0] queue_enable,
   output logic                         rd_req,
   output logic [NUM_OQ_WIDTH-1:0]      rd_oq,
   input  logic                         rd_ack,
   input  logic                         rd_done,
   output logic                         timeout_err,
   output logic [7:0]                   err_count
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] REQ    = 2'd1;
   localparam logic [1:0] BUSY   = 2'd2;
   localparam logic [1:0] SETTLE = 2'd3;

   localparam logic [NUM_OQ_WIDTH-1:0] LAST_GRANT_RST = NUM_OQ_WIDTH'(NUM_OUTPUT_QUEUES - 1);
   localparam logic [3:0]              SETTLE_LAST    = 4'(SETTLE_CYCLES - 1);

   logic [1:0]                   state;
   logic [NUM_OQ_WIDTH-1:0]      last_grant;
   logic [NUM_OQ_WIDTH-1:0]      grant;
   logic                         grant_valid;
   logic [NUM_OUTPUT_QUEUES-1:0] eligible;
   logic [TIMEOUT_WIDTH-1:0]     watchdog;
   logic [TIMEOUT_WIDTH-1:0]     watchdog_inc;
   logic [3:0]                   settle_cnt;
   int unsigned                  cand;

   assign eligible     = ~empty & out_rdy & queue_enable;
   assign watchdog_inc = watchdog + 1'b1;

   // Search upward from last_grant+1, wrapping; the first eligible queue wins.
   always_comb begin
      grant       = '0;
      grant_valid = 1'b0;
      cand        = 0;
      for (int unsigned i = 0; i < NUM_OUTPUT_QUEUES; i++) begin
         cand = 32'(last_grant) + 32'd1 + i;
         if (cand >= NUM_OUTPUT_QUEUES)
            cand = cand - NUM_OUTPUT_QUEUES;
         if (!grant_valid && eligible[NUM_OQ_WIDTH'(cand)]) begin
            grant_valid = 1'b1;
            grant       = NUM_OQ_WIDTH'(cand);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         rd_req      <= 1'b0;
         rd_oq       <= '0;
         last_grant  <= LAST_GRANT_RST;
         watchdog    <= '0;
         settle_cnt  <= '0;
         timeout_err <= 1'b0;
         err_count   <= '0;
      end else begin
         timeout_err <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_valid) begin
                  rd_oq      <= grant;
                  last_grant <= grant;
                  rd_req     <= 1'b1;
                  state      <= REQ;
               end
            end
            REQ: begin
               // A posted request is never withdrawn, whatever the eligibility inputs do.
               if (rd_ack) begin
                  rd_req   <= 1'b0;
                  watchdog <= '0;
                  if (rd_done) begin
                     settle_cnt <= '0;
                     state      <= SETTLE;
                  end else begin
                     state <= BUSY;
                  end
               end
            end
            BUSY: begin
               watchdog <= watchdog_inc;
               if (rd_done) begin
                  settle_cnt <= '0;
                  state      <= SETTLE;
               end else if (watchdog_inc == '1) begin
                  timeout_err <= 1'b1;
                  if (err_count != 8'hFF)
                     err_count <= err_count + 8'd1;
                  settle_cnt <= '0;
                  state      <= SETTLE;
               end
            end
            SETTLE: begin
               if (settle_cnt == SETTLE_LAST)
                  state <= IDLE;
               else
                  settle_cnt <= settle_cnt + 4'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
